// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store ports.
// Data wins by default; a streak limit bounds fetch starvation; a watchdog aborts hung accesses.
module mem_port_arbiter #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          busy,
    output logic          err
);

    localparam int unsigned WW = $clog2(TIMEOUT);
    localparam int unsigned SW = $clog2(MAX_DSTREAK + 1);
    localparam logic [WW-1:0] WaitLast  = WW'(TIMEOUT - 1);
    localparam logic [SW-1:0] StreakMax = SW'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        StIdle,
        StDBusy,
        StIBusy,
        StResp
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          m_req_q, m_req_d;
    logic          m_we_q, m_we_d;
    logic [AW-1:0] m_addr_q, m_addr_d;
    logic [DW-1:0] m_wdata_q, m_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          i_ready_q, i_ready_d;
    logic          d_ready_q, d_ready_d;
    logic          busy_q, busy_d;
    logic          err_q, err_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            streak_q  <= '0;
            wait_q    <= '0;
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            streak_q  <= streak_d;
            wait_q    <= wait_d;
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        streak_d  = streak_q;
        wait_d    = wait_q;
        m_req_d   = m_req_q;
        m_we_d    = m_we_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        i_ready_d = i_ready_q;
        d_ready_d = d_ready_q;
        err_d     = err_q;

        unique case (state_q)
            StIdle: begin
                // Data is older in program order, but only until the fetch-waiting streak runs out.
                if (d_req && (!i_req || (streak_q < StreakMax))) begin
                    state_d   = StDBusy;
                    streak_d  = i_req ? (streak_q + 1'b1) : '0;
                    m_req_d   = 1'b1;
                    m_we_d    = d_we;
                    m_addr_d  = d_addr;
                    m_wdata_d = d_wdata;
                    wait_d    = '0;
                end else if (i_req) begin
                    state_d   = StIBusy;
                    streak_d  = '0;
                    m_req_d   = 1'b1;
                    m_we_d    = 1'b0;
                    m_addr_d  = i_addr;
                    m_wdata_d = '0;
                    wait_d    = '0;
                end
            end

            StDBusy, StIBusy: begin
                if (m_ack) begin
                    m_req_d = 1'b0;
                    state_d = StResp;
                    if (state_q == StDBusy) begin
                        d_rdata_d = m_we_q ? '0 : m_rdata;
                        d_ready_d = 1'b1;
                    end else begin
                        i_rdata_d = m_rdata;
                        i_ready_d = 1'b1;
                    end
                end else if (wait_q == WaitLast) begin
                    // Watchdog abort: complete the requester with zero data and flag it.
                    m_req_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = StResp;
                    if (state_q == StDBusy) begin
                        d_rdata_d = '0;
                        d_ready_d = 1'b1;
                    end else begin
                        i_rdata_d = '0;
                        i_ready_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end

            StResp: begin
                i_ready_d = 1'b0;
                d_ready_d = 1'b0;
                state_d   = StIdle;
            end

            default: state_d = StIdle;
        endcase

        busy_d = (state_d != StIdle);
    end

    assign i_rdata = i_rdata_q;
    assign i_ready = i_ready_q;
    assign d_rdata = d_rdata_q;
    assign d_ready = d_ready_q;
    assign m_req   = m_req_q;
    assign m_we    = m_we_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign busy    = busy_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-schedule model checked every cycle, plus
// hand-computed expectations for latency, grant order, timeout and reset behaviour.
module tb_mem_port_arbiter;

    localparam int unsigned TO = 16;
    localparam int unsigned MD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, m_ack;
    logic [31:0] i_addr, d_addr, d_wdata, m_rdata;
    logic [31:0] i_rdata, d_rdata, m_addr, m_wdata;
    logic        i_ready, d_ready, m_req, m_we, busy, err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .AW(32), .DW(32), .TIMEOUT(TO), .MAX_DSTREAK(MD)
    ) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .busy(busy), .err(err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } dreq_t;

    logic [31:0] fq[$];
    dreq_t       dq[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ack_wait = 0;
    int mreq_age = 0;
    bit chk_en = 0;

    // Model: each granted access is a fixed schedule of m_req cycles, one ready cycle, done.
    logic [31:0] e_i_rdata, e_d_rdata, e_m_addr, e_m_wdata, mdl_res;
    logic        e_i_ready, e_d_ready, e_m_req, e_m_we, e_busy, e_err;
    bit          mdl_active, mdl_isd, mdl_to;
    int          mdl_age, mdl_dur, mdl_streak;
    string       mdl_log, dut_log;
    int          mreq_cnt;
    int          i_cyc[$];
    logic [31:0] last_i_rdata, last_d_rdata;

    initial begin
        {e_i_rdata, e_d_rdata, e_m_addr, e_m_wdata, mdl_res} = '0;
        {e_i_ready, e_d_ready, e_m_req, e_m_we, e_busy, e_err} = '0;
        mdl_active = 0; mdl_isd = 0; mdl_to = 0;
        mdl_age = 0; mdl_dur = 0; mdl_streak = 0;
        mdl_log = ""; dut_log = ""; mreq_cnt = 0;
        last_i_rdata = '0; last_d_rdata = '0;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h00C43821;
        return {a[15:0], 16'hBEEF};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=\"%s\" want=\"%s\"", name, act, exp);
        end
    endtask

    task automatic model_start(input bit isd, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
        mdl_active = 1;
        mdl_isd    = isd;
        mdl_age    = 0;
        mdl_to     = (ack_wait >= int'(TO));
        mdl_dur    = mdl_to ? int'(TO) : ack_wait + 1;
        mdl_res    = (mdl_to || we) ? 32'h0 : mem_word(addr);
        e_m_req    = 1'b1;
        e_m_we     = we;
        e_m_addr   = addr;
        e_m_wdata  = wdata;
        e_busy     = 1'b1;
        mdl_log    = {mdl_log, isd ? "D" : "I"};
    endtask

    task automatic model_update();
        if (reset) begin
            {e_i_rdata, e_d_rdata, e_m_addr, e_m_wdata} = '0;
            {e_i_ready, e_d_ready, e_m_req, e_m_we, e_busy, e_err} = '0;
            mdl_active = 0;
            mdl_streak = 0;
        end else if (mdl_active) begin
            mdl_age++;
            if (mdl_age == mdl_dur) begin
                e_m_req = 1'b0;
                if (mdl_to) e_err = 1'b1;
                if (mdl_isd) begin
                    e_d_ready = 1'b1;
                    e_d_rdata = mdl_res;
                end else begin
                    e_i_ready = 1'b1;
                    e_i_rdata = mdl_res;
                end
            end else if (mdl_age == mdl_dur + 1) begin
                e_i_ready  = 1'b0;
                e_d_ready  = 1'b0;
                e_busy     = 1'b0;
                mdl_active = 0;
            end
        end else if (d_req && (!i_req || mdl_streak < int'(MD))) begin
            mdl_streak = i_req ? mdl_streak + 1 : 0;
            model_start(1, d_we, d_addr, d_wdata);
        end else if (i_req) begin
            mdl_streak = 0;
            model_start(0, 1'b0, i_addr, 32'h0);
        end
    endtask

    task automatic drive_inputs();
        i_req   = (fq.size() > 0);
        i_addr  = i_req ? fq[0] : 32'h0;
        d_req   = (dq.size() > 0);
        d_we    = d_req ? dq[0].we : 1'b0;
        d_addr  = d_req ? dq[0].addr : 32'h0;
        d_wdata = d_req ? dq[0].wdata : 32'h0;
    endtask

    task automatic push_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        dreq_t r;
        r.we = we;
        r.addr = addr;
        r.wdata = wdata;
        dq.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_update();
        #1;
        if (e_i_ready && fq.size() > 0) void'(fq.pop_front());
        if (e_d_ready && dq.size() > 0) void'(dq.pop_front());
        if (m_req) begin
            m_ack = (mreq_age == ack_wait);
            mreq_age++;
        end else begin
            m_ack = 1'b0;
            mreq_age = 0;
        end
        m_rdata = mem_word(m_addr);
        drive_inputs();
    endtask

    task automatic run_idle(input string name, input int max_cyc);
        int n = 0;
        do begin
            step();
            n++;
        end while ((mdl_active || fq.size() > 0 || dq.size() > 0) && n < max_cyc);
        checks++;
        if (mdl_active || fq.size() > 0 || dq.size() > 0) begin
            errors++;
            $display("FAIL %s_budget got=still_busy want=idle within %0d cycles", name, max_cyc);
            fq.delete();
            dq.delete();
        end
    endtask

    task automatic clear_logs();
        dut_log  = "";
        mdl_log  = "";
        mreq_cnt = 0;
        i_cyc.delete();
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk1("busy", busy, e_busy);
            chk1("err", err, e_err);
            chk1("i_ready", i_ready, e_i_ready);
            chk1("d_ready", d_ready, e_d_ready);
            chk32("i_rdata", i_rdata, e_i_rdata);
            chk32("d_rdata", d_rdata, e_d_rdata);
            chk1("m_req", m_req, e_m_req);
            if (e_m_req) begin
                chk1("m_we", m_we, e_m_we);
                chk32("m_addr", m_addr, e_m_addr);
                chk32("m_wdata", m_wdata, e_m_wdata);
            end
            if (m_req) mreq_cnt++;
            if (i_ready) begin
                dut_log = {dut_log, "I"};
                i_cyc.push_back(cyc);
                last_i_rdata = i_rdata;
            end
            if (d_ready) begin
                dut_log = {dut_log, "D"};
                last_d_rdata = d_rdata;
            end
        end
    end

    initial begin
        int t0;
        reset = 1'b1;
        m_ack = 1'b0;
        m_rdata = '0;
        drive_inputs();
        step();
        chk_en = 1;
        step();
        reset = 1'b0;
        step();
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_m_req", m_req, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk32("rst_i_rdata", i_rdata, 32'h0);

        // Single zero-wait fetch.
        clear_logs();
        ack_wait = 0;
        t0 = cyc;
        fq.push_back(32'h4);
        drive_inputs();
        run_idle("fetch1", 20);
        chk_str("fetch1_log", dut_log, "I");
        chk_int("fetch1_mreq_cycles", mreq_cnt, 1);
        chk32("fetch1_rdata", last_i_rdata, 32'h00C43821);
        if (i_cyc.size() > 0) chk_int("fetch1_latency", i_cyc[0] - t0, 2);
        else chk_int("fetch1_pulses", 0, 1);

        // Store with two memory wait cycles.
        clear_logs();
        ack_wait = 2;
        push_d(1'b1, 32'h100, 32'h11);
        drive_inputs();
        run_idle("store", 20);
        chk_str("store_log", dut_log, "D");
        chk_int("store_mreq_cycles", mreq_cnt, 3);
        chk32("store_rdata", last_d_rdata, 32'h0);

        // Both ports saturated: fetch gets in after every fourth data grant.
        clear_logs();
        ack_wait = 1;
        for (int k = 0; k < 10; k++) push_d(1'b0, 32'h200 + 32'(4 * k), 32'h0);
        for (int k = 0; k < 3; k++) fq.push_back(32'h40 + 32'(4 * k));
        drive_inputs();
        run_idle("streak", 200);
        chk_str("streak_dut_order", dut_log, "DDDDIDDDDIDDI");
        chk_str("streak_model_order", mdl_log, "DDDDIDDDDIDDI");

        // Memory never answers: watchdog abort, then a normal access with err still set.
        clear_logs();
        ack_wait = 1000;
        push_d(1'b0, 32'h300, 32'h0);
        drive_inputs();
        run_idle("timeout", 40);
        chk_str("timeout_log", dut_log, "D");
        chk_int("timeout_mreq_cycles", mreq_cnt, 16);
        chk1("timeout_err", err, 1'b1);
        chk32("timeout_rdata", last_d_rdata, 32'h0);
        clear_logs();
        ack_wait = 0;
        fq.push_back(32'h8);
        drive_inputs();
        run_idle("after_to", 20);
        chk_str("after_to_log", dut_log, "I");
        chk1("after_to_err", err, 1'b1);
        chk32("after_to_rdata", last_i_rdata, 32'h0008BEEF);

        // Reset during D_BUSY, with a stray ack the cycle after.
        clear_logs();
        ack_wait = 1000;
        push_d(1'b1, 32'h400, 32'hAB);
        drive_inputs();
        step();
        chk1("pre_rst_m_req", m_req, 1'b1);
        reset = 1'b1;
        dq.delete();
        drive_inputs();
        step();
        reset = 1'b0;
        m_ack = 1'b1;
        chk1("midrst_m_req", m_req, 1'b0);
        chk1("midrst_busy", busy, 1'b0);
        chk1("midrst_err", err, 1'b0);
        chk1("midrst_m_we", m_we, 1'b0);
        chk32("midrst_m_addr", m_addr, 32'h0);
        chk32("midrst_i_rdata", i_rdata, 32'h0);
        step();
        step();
        step();
        chk_str("late_ack_log", dut_log, "");
        chk1("late_ack_busy", busy, 1'b0);

        // Chained fetches with i_req held across RESP.
        clear_logs();
        ack_wait = 0;
        fq.push_back(32'h0);
        fq.push_back(32'h4);
        fq.push_back(32'h8);
        drive_inputs();
        run_idle("chain", 40);
        chk_str("chain_log", dut_log, "III");
        chk_int("chain_mreq_cycles", mreq_cnt, 3);
        chk32("chain_last_rdata", last_i_rdata, 32'h0008BEEF);
        if (i_cyc.size() == 3) begin
            chk_int("chain_gap1", i_cyc[1] - i_cyc[0], 3);
            chk_int("chain_gap2", i_cyc[2] - i_cyc[1], 3);
        end else begin
            chk_int("chain_pulses", i_cyc.size(), 3);
        end

        step();
        step();
        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the processor's instruction-fetch port and its load/store data port.
- Sequences each access as a req/ack transaction on the memory side and returns a one-cycle ready pulse with read data to the winning requester.
- Data port has priority, since it belongs to the older instruction; a streak limit prevents fetch starvation.
- A watchdog aborts hung memory transactions and raises a sticky error.

Parameters:
- AW, 32: address width.
- DW, 32: data width.
- TIMEOUT, 16: memory-wait cycles before abort (≥2).
- MAX_DSTREAK, 4: consecutive data grants allowed while fetch waits (≥1).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- i_req  in  1  fetch request; held with i_addr stable until i_ready.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetched word, valid while i_ready=1.
- i_ready  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held with d_we/d_addr/d_wdata stable until d_ready.
- d_we  in  1  1=store, 0=load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data, valid while d_ready=1.
- d_ready  out  1  one-cycle data completion pulse.
- m_req  out  1  memory request, held until m_ack or abort.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data, valid with m_ack.
- m_ack  in  1  memory completion, one cycle; legal any cycle m_req=1, including the first.
- busy  out  1  1 whenever state≠IDLE.
- err  out  1  sticky timeout flag.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: all outputs 0, state IDLE, streak=0, wait counter=0. A reset mid-transaction drops m_req on that edge. Any later m_ack is ignored because IDLE ignores m_ack.
- States: IDLE, D_BUSY, I_BUSY, RESP. All outputs are registered.
- IDLE grant decision, evaluated each cycle:
  - If d_req=1 and (i_req=0 or streak<MAX_DSTREAK): grant data, go to D_BUSY. Increment streak if i_req=1, else clear it.
  - Else if i_req=1: grant fetch, go to I_BUSY, clear streak.
  - Else stay in IDLE.
- On grant: load m_addr/m_we/m_wdata from the winner (fetch forces m_we=0, m_wdata=0), set m_req=1, clear the wait counter.
- *_BUSY with m_ack=1:
  - m_req<=0.
  - Winner's rdata<=m_rdata; for stores rdata<=0.
  - Winner's ready<=1, go to RESP.
- *_BUSY with m_ack=0: wait counter +1. At TIMEOUT-1 with no ack:
  - m_req<=0, err<=1.
  - Winner's rdata<=0, winner's ready<=1, go to RESP (abort).
- RESP: exactly one cycle. The ready pulse is high, requests are ignored, rdata is held; ready<=0 and go to IDLE.
  - A requester may deassert req on the edge ending RESP, or keep it high with new operands to chain a request.
- Latency with zero-wait memory (ack in the first m_req cycle): req seen at cycle t → m_req high in t+1 → ready in t+2 → IDLE at t+3. That is 3 cycles per access; each memory wait cycle adds 1.
- rdata outputs hold their last value outside RESP.
- The non-granted port's ready stays 0.
- m_addr/m_we/m_wdata stay stable for the whole time m_req=1.
- err clears only on reset. The block keeps operating after a timeout.
- Simultaneous i_req and d_req with streak at the limit: fetch wins.

Test Plan:
- Reset, then i_req=1, i_addr=0x4, zero-wait memory returning 0x00C43821 → m_req high one cycle with m_addr=0x4, m_we=0. i_ready pulses 2 cycles after the request is seen, i_rdata=0x00C43821. busy drops the following cycle.
- Store: d_req=1, d_we=1, d_addr=0x100, d_wdata=0x11, 2 memory wait cycles → m_we=1, m_wdata=0x11 held 3 cycles. d_ready pulses once, d_rdata=0, i_ready stays 0.
- i_req and d_req both held high for 12 transactions, MAX_DSTREAK=4 → grant order D,D,D,D,I,D,D,D,D,I,…
- m_ack held 0, TIMEOUT=16 → m_req drops after 16 cycles, err=1 sticky. Winner ready pulses with rdata=0. A following request completes normally with err still 1.
- Reset asserted while in D_BUSY, with m_ack arriving the next cycle → all outputs 0 after the reset edge. The late m_ack produces no ready pulse, state stays IDLE.
- Chained fetches: i_req held high across RESP with i_addr 0x0→0x4→0x8 → three fetches completing every 3 cycles, each m_addr matching the issued address.
